ttl_and_arbiter_rr: RTL
=======================

// Module: ttl_and_arbiter_rr
// PURPOSE
//  Shares one WIDTH_IN-input AND evaluator among BLOCKS requesters.
//  Round-robin arbiter plus 3-state sequencer: grant, capture operand, evaluate, acknowledge.
//  Each requester has its own result bit in Y, which is held until that requester's next operation.
//  Sits beside the 74xx gate blocks when one gate must be time-shared on a common clock.
// PARAMETERS
//  BLOCKS      3  number of requesters (>=2)
//  WIDTH_IN    3  operand width per requester
//  DELAY_RISE  0  output rise delay, applied to Y, Ack, Grant, Busy
//  DELAY_FALL  0  output fall delay, applied to Y, Ack, Grant, Busy
// PORTS
//  Clk        input   1                 clock, rising edge
//  Clear_bar  input   1                 reset, synchronous, active-low
//  Req        input   BLOCKS            request per requester; held until Ack
//  A_2D       input   BLOCKS*WIDTH_IN   operands, packed; requester i owns bits [i*WIDTH_IN +: WIDTH_IN]
//  Grant      output  BLOCKS            one-hot owner; high in EVAL and ACK
//  Ack        output  BLOCKS            one-hot, one-cycle completion pulse
//  Y          output  BLOCKS            registered AND result per requester
//  Busy       output  1                 high whenever state != IDLE
// BEHAVIOUR
//  Reset: Clear_bar low at a rising Clk edge, in any state, forces the following:
//   - state IDLE
//   - Grant=0, Ack=0, Y=0, Busy=0
//   - round-robin pointer=0 (requester 0 highest priority)
//   - captured operand=0
//  States and transitions:
//   - IDLE: Req is sampled only here. If Req==0, stay in IDLE.
//     Otherwise the winner is the first set Req bit at or after the pointer, searching upward with wrap.
//     Register Grant=onehot(winner), capture A[winner], go to EVAL.
//   - EVAL: Y[winner] <= &captured; Ack[winner]=1 next; go to ACK. Other Y bits hold.
//   - ACK: Ack high this cycle only. Pointer <= (winner+1) mod BLOCKS.
//     Grant clears, go to IDLE.
//  Latency: Req seen at edge k; Grant valid after edge k; Y and Ack valid after edge k+1.
//   Y is valid in the same cycle Ack is high.
//  Throughput: one operation per 3 cycles, fair under full load.
//  Requester rule: drop Req on the edge that samples Ack=1.
//   A Req still high in the next IDLE is a new request.
//  Operand: A_2D is sampled once, at the grant edge. Later changes do not affect the result.
//  Req changes during EVAL/ACK are ignored; no pre-emption.
//  Req deasserted by a loser before it is granted: that request is lost, with no error.
//  Pointer wrap: BLOCKS-1 wins -> pointer=0.
//  Single requester under continuous load: re-granted each IDLE.
//  Reset asserted in EVAL: no Ack is issued and Y is cleared.
// CONFIGURATION
//  TTL_ARB_LOCK_EN defined:
//   - adds input Lock [BLOCKS-1:0] (placed after Req).
//   - In IDLE, if the previous winner p has Req[p]=1 and Lock[p]=1, p wins regardless of pointer.
//   - The pointer does not advance on a locked win.
//   - After reset, "previous winner" is none; lock has no effect until the first grant.
//  TTL_ARB_LOCK_EN undefined: no Lock port; pure round-robin.
// TESTING (BLOCKS=3, WIDTH_IN=3)
//  1. Reset, then Req=001, A_2D=9'b000_000_111 -> Grant=001 (1 edge), then Y=001 and Ack=001 (next edge), Busy=1 for 2 cycles.
//  2. Req=111 held continuously, all A=3'b111 -> grant order 0,1,2,0; each Ack is one cycle; 3 cycles apart.
//  3. Req=010, A[1]=3'b110 -> Y[1]=0; Y[0] and Y[2] unchanged from their prior values.
//  4. Change A[0] from 111 to 011 in the cycle after grant -> Y[0]=1, because the captured operand is used.
//  5. Clear_bar=0 during EVAL -> next cycle Grant=0, Ack=0, Y=000, IDLE; next Req=110 grants 1, since pointer=0.
//  6. LOCK_EN: Lock=100, Req=101 held -> requester 2 is re-granted repeatedly; drop Lock -> next grant goes to 0.

Source files
------------

// File: rtl/ttl_and_arbiter_rr.sv
// Time-shared WIDTH_IN-input AND evaluator serving BLOCKS requesters through a round-robin arbiter.
// Optional feature macro: TTL_ARB_LOCK_EN (adds Lock input so the previous winner can keep the evaluator).
module ttl_and_arbiter_rr #(
  parameter int BLOCKS     = 3,
  parameter int WIDTH_IN   = 3,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear_bar,
  input  logic [BLOCKS-1:0]            Req,
`ifdef TTL_ARB_LOCK_EN
  input  logic [BLOCKS-1:0]            Lock,
`endif
  input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
  output logic [BLOCKS-1:0]            Grant,
  output logic [BLOCKS-1:0]            Ack,
  output logic [BLOCKS-1:0]            Y,
  output logic                         Busy
);

  localparam int PW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int NOUT = 3 * BLOCKS + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]          state_r;
  logic [PW-1:0]       ptr_r;
  logic [PW-1:0]       win_r;
  logic [WIDTH_IN-1:0] cap_r;
  logic [BLOCKS-1:0]   grant_r;
  logic [BLOCKS-1:0]   ack_r;
  logic [BLOCKS-1:0]   y_r;
  logic                busy_r;
  logic                locked_r;

  logic [PW-1:0]       rr_idx_s;
  logic                rr_found_s;
  logic                take_lock_s;
  logic [PW-1:0]       next_win_s;
  logic [WIDTH_IN-1:0] cap_next_s;
  logic                any_req_s;

`ifdef TTL_ARB_LOCK_EN
  logic                prev_valid_r;
`endif

  function automatic logic [BLOCKS-1:0] onehot(input logic [PW-1:0] idx);
    logic [BLOCKS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first set Req bit at or above the pointer, wrapping to zero.
  always_comb begin
    int  cand;
    logic hit;
    rr_idx_s   = '0;
    rr_found_s = 1'b0;
    cand       = 0;
    hit        = 1'b0;
    for (int off = 0; off < BLOCKS; off++) begin
      cand       = int'(ptr_r) + off;
      cand       = (cand >= BLOCKS) ? (cand - BLOCKS) : cand;
      hit        = !rr_found_s && Req[PW'(cand)];
      rr_idx_s   = hit ? PW'(cand) : rr_idx_s;
      rr_found_s = rr_found_s | hit;
    end
  end

  // Winner selection, including the lock override when that feature is built in.
  always_comb begin
`ifdef TTL_ARB_LOCK_EN
    take_lock_s = prev_valid_r && Req[win_r] && Lock[win_r];
`else
    take_lock_s = 1'b0;
`endif
    next_win_s = take_lock_s ? win_r : rr_idx_s;
    cap_next_s = A_2D[int'(next_win_s)*WIDTH_IN +: WIDTH_IN];
    any_req_s  = |Req;
  end

  // Grant / evaluate / acknowledge sequencer and per-requester result register.
  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      state_r  <= S_IDLE;
      ptr_r    <= '0;
      win_r    <= '0;
      cap_r    <= '0;
      grant_r  <= '0;
      ack_r    <= '0;
      y_r      <= '0;
      busy_r   <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            state_r  <= S_EVAL;
            grant_r  <= onehot(next_win_s);
            win_r    <= next_win_s;
            cap_r    <= cap_next_s;
            busy_r   <= 1'b1;
            locked_r <= take_lock_s;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_EVAL: begin
          y_r[win_r] <= &cap_r;
          ack_r      <= grant_r;
          state_r    <= S_ACK;
        end
        S_ACK: begin
          ack_r   <= '0;
          grant_r <= '0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
          // A locked win keeps the rotation where it was.
          if (!locked_r) begin
            ptr_r <= (win_r == PW'(BLOCKS - 1)) ? '0 : PW'(win_r + 1'b1);
          end else begin
            ptr_r <= ptr_r;
          end
        end
        default: begin
          state_r <= S_IDLE;
          grant_r <= '0;
          ack_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TTL_ARB_LOCK_EN
  // Remembers whether any grant has happened since reset, so lock is inert until then.
  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      prev_valid_r <= 1'b0;
    end else if (state_r == S_ACK) begin
      prev_valid_r <= 1'b1;
    end else begin
      prev_valid_r <= prev_valid_r;
    end
  end
`endif

  logic [NOUT-1:0] raw_s;
  logic [NOUT-1:0] dly_s;

  assign raw_s = {grant_r, ack_r, y_r, busy_r};

  // Rise/fall delays are counted in Clk cycles; a level must persist that long to reach the pin.
  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
    assign dly_s = raw_s;
  end else begin : g_dly
    localparam int DMAX = (DELAY_RISE > DELAY_FALL) ? DELAY_RISE : DELAY_FALL;
    localparam int CW   = $clog2(DMAX + 1);
    for (genvar b = 0; b < NOUT; b++) begin : g_bit
      logic          q_r;
      logic [CW-1:0] cnt_r;
      int            tgt_s;

      // Delay selected by the direction the bit is heading.
      always_comb begin
        tgt_s = raw_s[b] ? DELAY_RISE : DELAY_FALL;
      end

      // Inertial filter: follows the source once it has differed for the selected delay.
      always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
          q_r   <= 1'b0;
          cnt_r <= '0;
        end else if (raw_s[b] == q_r) begin
          cnt_r <= '0;
        end else if (int'(cnt_r) + 1 >= tgt_s) begin
          q_r   <= raw_s[b];
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + 1'b1;
        end
      end

      assign dly_s[b] = (raw_s[b] != q_r && tgt_s == 0) ? raw_s[b] : q_r;
    end
  end

  assign {Grant, Ack, Y, Busy} = dly_s;

endmodule
